// File: rtl/bsg_chip_pkg.sv
// Chip-wide shared types and defaults for the SDR link front end.
package bsg_chip_pkg;

    localparam int width_gp        = 32;
    localparam int sdr_num_chan_gp = 4;

    // Link framing header carried alongside each payload word.
    typedef struct packed {
        logic [$clog2(sdr_num_chan_gp)-1:0] tag;
    } sdr_chan_hdr_s;

endpackage

// File: rtl/bsg_sdr_credit_counter.sv
// Purpose: per-channel downstream credit count, saturating at credits_p.
// Latency: count updates on the clock after inc/dec; nonzero_o is a direct decode of the count.
// Backpressure: none; the owner must not decrement at zero.
module bsg_sdr_credit_counter #(
    parameter int credits_p = 8,
    parameter int width_lp  = $clog2(credits_p + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o
);

    localparam logic [width_lp-1:0] full_lp = width_lp'(credits_p);

    logic [width_lp-1:0] cnt_q, cnt_d;

    // A send and a return in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != full_lp))
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !inc_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= full_lp;
        end else begin
            cnt_q <= cnt_d;
            if (inc_i && !dec_i)
                assert (cnt_q != full_lp)
                    else $warning("credit return overflows saturated count");
        end
    end

    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/bsg_sdr_channel_mux.sv
// Purpose: round-robin merge of num_chan_p credited channels onto one tagged link; BSG_SDR_CHANNEL_MUX_STATS_EN adds per-channel word counters.
// Latency: one cycle from channel handshake to link_v_o.
// Backpressure: no grants while the output register is full and link_ready_i is low; no grant to a channel without credit.
module bsg_sdr_channel_mux
    import bsg_chip_pkg::*;
#(
    parameter int width_p      = width_gp,
    parameter int num_chan_p   = sdr_num_chan_gp,
    parameter int credits_p    = 8,
    parameter int tag_width_lp = $clog2(num_chan_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [num_chan_p*width_p-1:0] chan_data_i,
    input  logic [num_chan_p-1:0]        chan_v_i,
    output logic [num_chan_p-1:0]        chan_ready_o,
    output logic [width_p-1:0]           link_data_o,
    output logic [tag_width_lp-1:0]      link_tag_o,
    output logic                         link_v_o,
    input  logic                         link_ready_i,
    input  logic                         credit_v_i,
    input  logic [tag_width_lp-1:0]      credit_tag_i,
    output logic [num_chan_p*32-1:0]     stats_o
);

    logic [num_chan_p-1:0]   nonzero, eligible, grant_oh, xfer, credit_inc;
    logic [tag_width_lp-1:0] rr_ptr_q, rr_ptr_d, grant_idx, link_tag_q;
    logic [width_p-1:0]      link_data_q;
    logic                    link_v_q, accept, grant_found;

    assign accept   = !link_v_q || link_ready_i;
    assign eligible = chan_v_i & nonzero;

    // First eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int off = 0; off < num_chan_p; off++) begin
            idx = (int'(rr_ptr_q) + off) % num_chan_p;
            if (!grant_found && eligible[idx]) begin
                grant_found   = 1'b1;
                grant_idx     = tag_width_lp'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    assign rr_ptr_d     = (int'(grant_idx) == num_chan_p - 1) ? '0 : grant_idx + 1'b1;
    assign chan_ready_o = (accept && !reset_i) ? grant_oh : '0;
    assign xfer         = chan_v_i & chan_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            link_v_q    <= 1'b0;
            link_data_q <= '0;
            link_tag_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            if (|xfer) begin
                link_v_q    <= 1'b1;
                link_data_q <= chan_data_i[int'(grant_idx)*width_p +: width_p];
                link_tag_q  <= grant_idx;
                rr_ptr_q    <= rr_ptr_d;
            end else if (link_ready_i) begin
                link_v_q    <= 1'b0;
            end
            if (credit_v_i)
                assert (int'(credit_tag_i) < num_chan_p)
                    else $warning("credit return with out-of-range tag %0d", credit_tag_i);
        end
    end

    for (genvar i = 0; i < num_chan_p; i++) begin : g_chan
        assign credit_inc[i] = credit_v_i && (int'(credit_tag_i) == i);

        bsg_sdr_credit_counter #(.credits_p(credits_p)) u_credit (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .inc_i     (credit_inc[i]),
            .dec_i     (xfer[i]),
            .nonzero_o (nonzero[i])
        );
    end

`ifdef BSG_SDR_CHANNEL_MUX_STATS_EN
    logic [num_chan_p-1:0][31:0] stats_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stats_q <= '0;
        end else begin
            for (int i = 0; i < num_chan_p; i++)
                if (xfer[i]) stats_q[i] <= stats_q[i] + 32'd1;
        end
    end

    assign stats_o = stats_q;
`else
    assign stats_o = '0;
`endif

    assign link_v_o    = link_v_q;
    assign link_data_o = link_data_q;
    assign link_tag_o  = link_tag_q;

endmodule

// File: tb/tb_bsg_sdr_channel_mux.sv
// Scenario bench for bsg_sdr_channel_mux: 4 channels, 2 credits each, 16-bit payload.
module tb_bsg_sdr_channel_mux;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int C  = 2;
    localparam int TW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i;
    logic [N*W-1:0]    chan_data_i;
    logic [N-1:0]      chan_v_i;
    logic [N-1:0]      chan_ready_o;
    logic [W-1:0]      link_data_o;
    logic [TW-1:0]     link_tag_o;
    logic              link_v_o;
    logic              link_ready_i;
    logic              credit_v_i;
    logic [TW-1:0]     credit_tag_i;
    logic [N*32-1:0]   stats_o;

    logic [W-1:0]      chan_word [N];
    logic [TW+W-1:0]   exp_q [$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                test_id = 0;

    bsg_sdr_channel_mux #(.width_p(W), .num_chan_p(N), .credits_p(C)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .chan_data_i  (chan_data_i),
        .chan_v_i     (chan_v_i),
        .chan_ready_o (chan_ready_o),
        .link_data_o  (link_data_o),
        .link_tag_o   (link_tag_o),
        .link_v_o     (link_v_o),
        .link_ready_i (link_ready_i),
        .credit_v_i   (credit_v_i),
        .credit_tag_i (credit_tag_i),
        .stats_o      (stats_o)
    );

    always_comb begin
        chan_data_i = '0;
        for (int i = 0; i < N; i++) chan_data_i[i*W +: W] = chan_word[i];
    end

    function automatic logic [W-1:0] word_of(int t, int ch);
        return 16'(32'hA000 + t * 16 + ch);
    endfunction

    task automatic set_words();
        for (int ch = 0; ch < N; ch++) chan_word[ch] = word_of(test_id, ch);
    endtask

    task automatic push_exp(int ch);
        exp_q.push_back({TW'(ch), word_of(test_id, ch)});
    endtask

    // Scoreboard: every link handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset_i && link_v_o && link_ready_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL link_word unexpected: got tag=%0d data=%h, required none", link_tag_o, link_data_o);
            end else if ({link_tag_o, link_data_o} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL link_word: got tag=%0d data=%h, required tag=%0d data=%h",
                         link_tag_o, link_data_o, exp_q[0][TW+W-1:W], exp_q[0][W-1:0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        chan_v_i     = '0;
        credit_v_i   = 1'b0;
        credit_tag_i = '0;
        link_ready_i = 1'b1;
        repeat (2) step();
        reset_i = 1'b0;
    endtask

    task automatic check_drained(string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        test_id = 0; set_words();
        reset_i = 1'b1; chan_v_i = '1; link_ready_i = 1'b1;
        credit_v_i = 1'b0; credit_tag_i = '0;
        repeat (2) step();
        #1;
        n_tests++;
        if ({link_v_o, link_tag_o, link_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_link: got v=%b tag=%0d data=%h, required all 0", link_v_o, link_tag_o, link_data_o);
        end
        n_tests++;
        if (chan_ready_o !== '0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 0000", chan_ready_o);
        end
        n_tests++;
        if (stats_o !== '0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h, required 0", stats_o);
        end
        chan_v_i = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] one, exp_r;
        one = 1;
        test_id = 1; set_words(); do_reset();
        chan_v_i = '1;
        for (int k = 0; k < 12; k++) begin
            exp_r = (k < 8) ? (one << (k % 4)) : '0;
            if (k < 8) push_exp(k % 4);
            #1;
            n_tests++;
            if (chan_ready_o !== exp_r) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d: got %b, required %b", k, chan_ready_o, exp_r);
            end
            step();
        end
        n_tests++;
        if (link_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_credits_spent: got link_v=%b, required 0", link_v_o);
        end
        chan_v_i = '0;
        check_drained("rr");
    endtask

    task automatic test_starvation();
        logic [N-1:0] exp_r;
        test_id = 2; set_words(); do_reset();
        chan_v_i = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            exp_r = (k < 2) ? 4'b0100 : 4'b0000;
            if (k < 2) push_exp(2);
            #1;
            n_tests++;
            if (chan_ready_o !== exp_r) begin
                n_fail++;
                $display("FAIL starve_grant cycle %0d: got %b, required %b", k, chan_ready_o, exp_r);
            end
            step();
        end
        credit_v_i = 1'b1; credit_tag_i = 2'd2;
        #1;
        n_tests++;
        if (chan_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL starve_same_cycle: got %b, required 0000", chan_ready_o);
        end
        step();
        credit_v_i = 1'b0;
        push_exp(2);
        #1;
        n_tests++;
        if (chan_ready_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL starve_after_credit: got %b, required 0100", chan_ready_o);
        end
        step();
        #1;
        n_tests++;
        if (chan_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL starve_exhausted: got %b, required 0000", chan_ready_o);
        end
        repeat (2) step();
        chan_v_i = '0;
        check_drained("starve");
    endtask

    task automatic test_backpressure();
        logic [N-1:0] one, exp_r;
        one = 1;
        test_id = 3; set_words(); do_reset();
        link_ready_i = 1'b0;
        chan_v_i = 4'b0001;
        push_exp(0);
        #1;
        n_tests++;
        if (chan_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_first_grant: got %b, required 0001", chan_ready_o);
        end
        step();
        chan_v_i = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if ({chan_ready_o, link_v_o, link_tag_o, link_data_o} !== {4'b0000, 1'b1, 2'd0, word_of(3, 0)}) begin
                n_fail++;
                $display("FAIL bp_stall cycle %0d: got ready=%b v=%b tag=%0d data=%h, required ready=0000 v=1 tag=0 data=%h",
                         k, chan_ready_o, link_v_o, link_tag_o, link_data_o, word_of(3, 0));
            end
            step();
        end
        link_ready_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_r = (k < 7) ? (one << ((k + 1) % 4)) : '0;
            if (k < 7) push_exp((k + 1) % 4);
            #1;
            n_tests++;
            if (chan_ready_o !== exp_r) begin
                n_fail++;
                $display("FAIL bp_release cycle %0d: got %b, required %b", k, chan_ready_o, exp_r);
            end
            step();
        end
        chan_v_i = '0;
        step();
        check_drained("bp");
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] exp_seq [7];
        exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0000};
        test_id = 4; set_words(); do_reset();
        for (int k = 0; k < 7; k++) begin
            chan_v_i   = (k < 3) ? 4'b0010 : 4'b0110;
            credit_v_i = (k == 0) || (k == 3);
            credit_tag_i = 2'd1;
            if (exp_seq[k] == 4'b0010) push_exp(1);
            if (exp_seq[k] == 4'b0100) push_exp(2);
            #1;
            n_tests++;
            if (chan_ready_o !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL simul_grant cycle %0d: got %b, required %b", k, chan_ready_o, exp_seq[k]);
            end
            step();
        end
        chan_v_i = '0; credit_v_i = 1'b0;
        step();
        check_drained("simul");

        // Credit return at full count must saturate, not add a third credit.
        test_id = 5; set_words(); do_reset();
        credit_v_i = 1'b1; credit_tag_i = 2'd0;
        step();
        credit_v_i = 1'b0;
        chan_v_i = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            if (k < 2) push_exp(0);
            #1;
            n_tests++;
            if (chan_ready_o !== ((k < 2) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL overflow_sat cycle %0d: got %b, required %b", k, chan_ready_o, (k < 2) ? 4'b0001 : 4'b0000);
            end
            step();
        end
        chan_v_i = '0;
        step();
        check_drained("overflow");
    endtask

    task automatic test_midreset_stats();
        logic [N-1:0] one, exp_r;
        logic [31:0]  exp_stat;
        one = 1;
        test_id = 6; set_words(); do_reset();
        chan_v_i = '1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) push_exp(k);
            step();
        end
        link_ready_i = 1'b0;
        reset_i = 1'b1;
        #1;
        n_tests++;
        if (chan_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b, required 0000", chan_ready_o);
        end
        step();
        n_tests++;
        if ({link_v_o, link_tag_o, link_data_o} !== '0) begin
            n_fail++;
            $display("FAIL midreset_link: got v=%b tag=%0d data=%h, required all 0", link_v_o, link_tag_o, link_data_o);
        end
        reset_i = 1'b0; link_ready_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_r = (k < 8) ? (one << (k % 4)) : '0;
            if (k < 8) push_exp(k % 4);
            #1;
            n_tests++;
            if (chan_ready_o !== exp_r) begin
                n_fail++;
                $display("FAIL midreset_refill cycle %0d: got %b, required %b", k, chan_ready_o, exp_r);
            end
            step();
        end
        chan_v_i = '0;
        step();
        check_drained("midreset");

        test_id = 7; set_words(); do_reset();
        chan_v_i = 4'b1000; credit_tag_i = 2'd3;
        for (int k = 0; k < 7; k++) begin
            credit_v_i = (k >= 1);
            push_exp(3);
            #1;
            n_tests++;
            if (chan_ready_o !== 4'b1000) begin
                n_fail++;
                $display("FAIL stats_grant cycle %0d: got %b, required 1000", k, chan_ready_o);
            end
            step();
        end
        chan_v_i = '0; credit_v_i = 1'b1;
        step();
        credit_v_i = 1'b0;
        step();
`ifdef BSG_SDR_CHANNEL_MUX_STATS_EN
        exp_stat = 32'd7;
`else
        exp_stat = 32'd0;
`endif
        n_tests++;
        if (stats_o !== {exp_stat, 96'd0}) begin
            n_fail++;
            $display("FAIL stats_count: got %h, required %h", stats_o, {exp_stat, 96'd0});
        end
        check_drained("stats");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_starvation();
        test_backpressure();
        test_simultaneous();
        test_midreset_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
